// File: rtl/memory_f1_pkg.sv
// memory_f1_pkg: shared timing constants and FSM encoding for the F1 store tank controllers.
// Contents: DIGITS_DEF/WORDS_DEF defaults, CIRC circulation length, state_t FSM encoding.
package memory_f1_pkg;

    localparam int DIGITS_DEF = 18;
    localparam int WORDS_DEF  = 32;
    localparam int CIRC       = DIGITS_DEF * WORDS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DONE
    } state_t;

endpackage

// File: rtl/memory_f1_up_1_ctl_if.sv
// memory_f1_up_1_ctl_if: request/acknowledge bus between a requester and a tank controller.
// Signals: f1_req, f1_we, f1_long, f1_addr (requester to controller); f1_busy, f1_ack (controller to requester).
interface memory_f1_up_1_ctl_if;

    logic       f1_req;
    logic       f1_we;
    logic       f1_long;
    logic [4:0] f1_addr;
    logic       f1_busy;
    logic       f1_ack;

    modport master (
        output f1_req, f1_we, f1_long, f1_addr,
        input  f1_busy, f1_ack
    );

    modport slave (
        input  f1_req, f1_we, f1_long, f1_addr,
        output f1_busy, f1_ack
    );

endinterface

// File: rtl/memory_f1_timing.sv
// memory_f1_timing: free-running digit/minor-cycle counter pair shared by every tank controller.
// Ports: clk, rst_n (async active-low); digit (0..DIGITS-1), minor (0..WORDS-1), carry (high on the last digit).
module memory_f1_timing
    import memory_f1_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int WORDS  = WORDS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] digit,
    output logic [4:0] minor,
    output logic       carry
);

    localparam logic [4:0] D_LAST = 5'(DIGITS - 1);
    localparam logic [4:0] W_LAST = 5'(WORDS - 1);

    assign carry = digit == D_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
            minor <= '0;
        end else begin
            digit <= carry ? '0 : digit + 5'd1;
            if (carry)
                minor <= minor == W_LAST ? '0 : minor + 5'd1;
        end
    end

endmodule

// File: rtl/memory_f1_up_1_ctl.sv
// memory_f1_up_1_ctl: access controller for mercury tank 1 of the upper F1 store.
// Ports: f1_clk, f1_rst_n (async active-low); bus (slave: req/we/long/addr in, busy/ack out);
//        f1_up_t1_clr/in/out gating strobes to the delay line; f1_digit/f1_minor timing counters.
module memory_f1_up_1_ctl
    import memory_f1_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int WORDS  = WORDS_DEF
) (
    input  logic                 f1_clk,
    input  logic                 f1_rst_n,
    memory_f1_up_1_ctl_if.slave  bus,
    output logic                 f1_up_t1_clr,
    output logic                 f1_up_t1_in,
    output logic                 f1_up_t1_out,
    output logic [4:0]           f1_digit,
    output logic [4:0]           f1_minor
);

    localparam logic [4:0] W_LAST     = 5'(WORDS - 1);
    localparam logic [5:0] SHORT_LAST = 6'(DIGITS - 1);
    localparam logic [5:0] LONG_LAST  = 6'(2 * DIGITS - 1);

    state_t     state;
    logic       we_q;
    logic       long_q;
    logic       ack;
    logic       carry;
    logic [4:0] slot;
    logic [4:0] slot_prev;
    logic [5:0] span;

    memory_f1_timing #(
        .DIGITS (DIGITS),
        .WORDS  (WORDS)
    ) u_timing (
        .clk   (f1_clk),
        .rst_n (f1_rst_n),
        .digit (f1_digit),
        .minor (f1_minor),
        .carry (carry)
    );

    // The transfer is launched on the edge leaving the last digit of the
    // preceding minor cycle, so the first XFER cycle shows (slot, 0).
    assign slot_prev   = slot == '0 ? W_LAST : slot - 5'd1;
    assign bus.f1_busy = state != ST_IDLE;
    assign bus.f1_ack  = ack;

    // Trigger is only examined in WAIT, so an acceptance edge that happens to
    // sit on the trigger point costs a full circulation.
    always_ff @(posedge f1_clk or negedge f1_rst_n) begin
        if (!f1_rst_n) begin
            state        <= ST_IDLE;
            we_q         <= 1'b0;
            long_q       <= 1'b0;
            slot         <= '0;
            span         <= '0;
            ack          <= 1'b0;
            f1_up_t1_clr <= 1'b0;
            f1_up_t1_in  <= 1'b0;
            f1_up_t1_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.f1_req) begin
                    state  <= ST_WAIT;
                    we_q   <= bus.f1_we;
                    long_q <= bus.f1_long;
                    slot   <= bus.f1_long ? {bus.f1_addr[4:1], 1'b0} : bus.f1_addr;
                end
                ST_WAIT: if (carry && f1_minor == slot_prev) begin
                    state        <= ST_XFER;
                    span         <= '0;
                    f1_up_t1_clr <= we_q;
                    f1_up_t1_in  <= we_q;
                    f1_up_t1_out <= !we_q;
                end
                ST_XFER: if (span == (long_q ? LONG_LAST : SHORT_LAST)) begin
                    state        <= ST_DONE;
                    ack          <= 1'b1;
                    f1_up_t1_clr <= 1'b0;
                    f1_up_t1_in  <= 1'b0;
                    f1_up_t1_out <= 1'b0;
                end else begin
                    span <= span + 6'd1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ack   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_f1_up_1_ctl.sv
// tb_memory_f1_up_1_ctl: scoreboard bench for the tank 1 access controller.
// Stimulus pushes the expected transfer window of each request into a queue;
// a negedge monitor compares counters, strobes, ack and busy every cycle.
module tb_memory_f1_up_1_ctl;
    import memory_f1_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       t1_clr, t1_in, t1_out;
    logic [4:0] digit, minor;

    memory_f1_up_1_ctl_if bus();

    memory_f1_up_1_ctl dut (
        .f1_clk       (clk),
        .f1_rst_n     (rst_n),
        .bus          (bus),
        .f1_up_t1_clr (t1_clr),
        .f1_up_t1_in  (t1_in),
        .f1_up_t1_out (t1_out),
        .f1_digit     (digit),
        .f1_minor     (minor)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int start;
        int len;
        bit we;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   free_at = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   st;

    // Cycle index since reset release; the counters must show cyc mod CIRC.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Wait until the controller is idle and the counters show position p.
    task automatic align(input int p);
        while (cyc < free_at || cyc % CIRC != p) step();
    endtask

    // Issue one request at the current cycle c; it is accepted on the edge
    // closing cycle c. The transfer starts at the first cycle >= c+2 whose
    // position equals the effective slot start.
    task automatic req_txn(input bit w, input bit l, input logic [4:0] a, input bit keep, output int start);
        int   c, s;
        txn_t t;
        while (cyc < free_at) step();
        bus.f1_req  = 1'b1;
        bus.f1_we   = w;
        bus.f1_long = l;
        bus.f1_addr = a;
        c = cyc;
        s = (l ? int'(a) / 2 * 2 : int'(a)) * DIGITS_DEF;
        t.acc   = c + 1;
        t.start = c + 2 + (((s - c - 2) % CIRC) + CIRC) % CIRC;
        t.len   = l ? 2 * DIGITS_DEF : DIGITS_DEF;
        t.we    = w;
        q.push_back(t);
        free_at = t.start + t.len + 1;
        start   = t.start;
        step();
        if (!keep) bus.f1_req = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        int pos;
        bit act_x, e_ack, e_busy, w;
        if (mon_en && rst_n) begin
            pos = cyc % CIRC;
            chk("digit", int'(digit), pos % DIGITS_DEF);
            chk("minor", int'(minor), pos / DIGITS_DEF);
            act_x = 1'b0; e_ack = 1'b0; e_busy = 1'b0; w = 1'b0;
            if (q.size() > 0) begin
                act_x  = cyc >= q[0].start && cyc < q[0].start + q[0].len;
                e_ack  = cyc == q[0].start + q[0].len;
                e_busy = cyc >= q[0].acc && cyc <= q[0].start + q[0].len;
                w      = q[0].we;
            end
            chk("clr",  int'(t1_clr),      int'(act_x && w));
            chk("in",   int'(t1_in),       int'(act_x && w));
            chk("out",  int'(t1_out),      int'(act_x && !w));
            chk("ack",  int'(bus.f1_ack),  int'(e_ack));
            chk("busy", int'(bus.f1_busy), int'(e_busy));
            if (e_ack) void'(q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.f1_req  = 1'b0;
        bus.f1_we   = 1'b0;
        bus.f1_long = 1'b0;
        bus.f1_addr = '0;
        @(posedge clk);
        #1;
        chk("rst_clr",   int'(t1_clr), 0);
        chk("rst_in",    int'(t1_in), 0);
        chk("rst_out",   int'(t1_out), 0);
        chk("rst_ack",   int'(bus.f1_ack), 0);
        chk("rst_busy",  int'(bus.f1_busy), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_minor", int'(minor), 0);
        step();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (600) step();

        // short write, slot 5, requested at (0,3)
        align(3);
        req_txn(1'b1, 1'b0, 5'd5, 1'b0, st);

        // long read, slot 7 -> effective slot 6
        req_txn(1'b0, 1'b1, 5'd7, 1'b0, st);

        // acceptance on the trigger point (3,17) for slot 4
        align(3 * DIGITS_DEF + 17);
        req_txn(1'b0, 1'b0, 5'd4, 1'b0, st);

        // long slot 30 ends at the circulation wrap
        req_txn(1'b1, 1'b1, 5'd31, 1'b0, st);

        // request held high with changing inputs while busy, then back-to-back
        req_txn(1'b1, 1'b0, 5'd12, 1'b1, st);
        while (cyc + 1 < free_at) begin
            step();
            bus.f1_addr = 5'($urandom);
            bus.f1_we   = 1'($urandom);
            bus.f1_long = 1'($urandom);
        end
        req_txn(1'b0, 1'b0, 5'd20, 1'b0, st);

        // randomized requests at random alignment
        for (int i = 0; i < 8; i++) begin
            align($urandom_range(0, CIRC - 1));
            req_txn(1'($urandom), 1'($urandom), 5'($urandom), 1'b0, st);
        end

        // reset asserted in XFER cycle 9
        req_txn(1'b1, 1'b0, 5'd10, 1'b0, st);
        while (cyc < st + 9) step();
        chk("pre_rst_clr", int'(t1_clr), 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_clr",  int'(t1_clr), 0);
        chk("mid_rst_in",   int'(t1_in), 0);
        chk("mid_rst_out",  int'(t1_out), 0);
        chk("mid_rst_ack",  int'(bus.f1_ack), 0);
        chk("mid_rst_busy", int'(bus.f1_busy), 0);
        q.delete();
        step();
        step();
        rst_n   = 1'b1;
        free_at = 0;
        chk("rel_digit", int'(digit), 0);
        chk("rel_minor", int'(minor), 0);
        mon_en = 1'b1;
        repeat (40) step();

        while (cyc < free_at) step();
        step();
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
